input_debounce: RTL

- Upstream conditioning stage for double_edge_detect. Takes a raw asynchronous level (button or external strobe) and passes it through a synchronizer chain.
- Filters out bounce and glitches with a counter-qualified FSM, then drives a clean, single-clock-domain level into double_edge_detect's `in` port.
- Also reports filtered-glitch activity for debug.

---
 rtl/debounce_pkg.sv | 29 ++
 rtl/sync_chain.sv | 21 ++
 rtl/input_debounce.sv | 134 +++++++++++++
 3 files changed

// File: rtl/debounce_pkg.sv
// Shared definitions for the input debounce block and its synchronizer.
package debounce_pkg;

  // Two-bit FSM encoding; all four codes are used.
  typedef enum logic [1:0] {
    ST_LOW       = 2'd0,
    ST_PEND_HIGH = 2'd1,
    ST_HIGH      = 2'd2,
    ST_PEND_LOW  = 2'd3
  } state_t;

  // Legal parameter ranges.
  localparam int SYNC_STAGES_MIN = 2;
  localparam int SYNC_STAGES_MAX = 4;
  localparam int DEBOUNCE_MIN    = 2;
  localparam int GLITCH_W_MIN    = 1;

  // True when the parameter set is usable: the counter must be able to
  // hold DEBOUNCE_CYCLES-1 without wrapping.
  function automatic bit params_ok(input int sync_stages, input int debounce_cycles,
                                   input int cnt_w, input int glitch_w);
    return (sync_stages >= SYNC_STAGES_MIN) && (sync_stages <= SYNC_STAGES_MAX) &&
           (debounce_cycles >= DEBOUNCE_MIN) &&
           (cnt_w >= 1) && (cnt_w < 31) &&
           (debounce_cycles <= (1 << cnt_w) - 1) &&
           (glitch_w >= GLITCH_W_MIN);
  endfunction

endpackage

// File: rtl/sync_chain.sv
// Multi-flop synchronizer for a single asynchronous level.
module sync_chain #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,   // active-low, asynchronous
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sq;

  // Shift the raw level through STAGES flops; only stage 0 sees d.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) sq <= '0;
    else        sq <= {sq[STAGES-2:0], d};
  end

  assign q = sq[STAGES-1];

endmodule

// File: rtl/input_debounce.sv
// Debounces a raw asynchronous level: synchronize, then qualify each level
// change with DEBOUNCE_CYCLES consecutive agreeing samples. Aborted pending
// transitions are counted (saturating) for debug.
module input_debounce
  import debounce_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 8,
  parameter int CNT_W           = 4,
  parameter int GLITCH_W        = 8
) (
  input  logic                clk,
  input  logic                reset,   // active-low, asynchronous
  input  logic                in_raw,
  output logic                out,
  output logic                rise,
  output logic                fall,
  output logic [GLITCH_W-1:0] glitch_cnt
);

  localparam bit             PARAMS_OK = params_ok(SYNC_STAGES, DEBOUNCE_CYCLES, CNT_W, GLITCH_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [GLITCH_W-1:0] GLITCH_MAX = {GLITCH_W{1'b1}};
  localparam logic [GLITCH_W-1:0] GLITCH_ONE = GLITCH_W'(1);

  logic             sync_q;
  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             out_nxt, rise_nxt, fall_nxt, glitch_inc;

  sync_chain #(.STAGES(SYNC_STAGES)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (in_raw),
    .q     (sync_q)
  );

  // Flag an unusable parameter set in simulation.
  always_ff @(posedge clk) begin
    assert (PARAMS_OK);
  end

  // State and qualification counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_LOW;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next state, counter and registered-output next values.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    out_nxt    = out;
    rise_nxt   = 1'b0;
    fall_nxt   = 1'b0;
    glitch_inc = 1'b0;
    case (state)
      ST_LOW: begin
        out_nxt = 1'b0;
        if (sync_q) begin
          state_nxt = ST_PEND_HIGH;
          cnt_nxt   = CNT_ONE;
        end
      end
      ST_PEND_HIGH: begin
        if (!sync_q) begin
          state_nxt  = ST_LOW;
          cnt_nxt    = '0;
          glitch_inc = 1'b1;
        end else if (cnt == CNT_LAST) begin
          state_nxt = ST_HIGH;
          cnt_nxt   = '0;
          out_nxt   = 1'b1;
          rise_nxt  = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      ST_HIGH: begin
        out_nxt = 1'b1;
        if (!sync_q) begin
          state_nxt = ST_PEND_LOW;
          cnt_nxt   = CNT_ONE;
        end
      end
      ST_PEND_LOW: begin
        if (sync_q) begin
          state_nxt  = ST_HIGH;
          cnt_nxt    = '0;
          glitch_inc = 1'b1;
        end else if (cnt == CNT_LAST) begin
          state_nxt = ST_LOW;
          cnt_nxt   = '0;
          out_nxt   = 1'b0;
          fall_nxt  = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      default: begin
        // Unreachable code: fall back to a known idle state.
        state_nxt = ST_LOW;
        cnt_nxt   = '0;
        out_nxt   = 1'b0;
      end
    endcase
  end

  // Registered level and edge pulses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out  <= 1'b0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      out  <= out_nxt;
      rise <= rise_nxt;
      fall <= fall_nxt;
    end
  end

  // Saturating count of aborted pending transitions.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                  glitch_cnt <= '0;
    else if (glitch_inc && glitch_cnt != GLITCH_MAX) glitch_cnt <= glitch_cnt + GLITCH_ONE;
  end

endmodule
